// File: rtl/systolic_pkg.sv
// Shared definitions for the 2x2 systolic multiplier blocks: matrix size,
// default word width, collector state encoding and element indices.
package systolic_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int N              = 2;
  localparam int NUM_ELEMS      = N * N;

  localparam logic [1:0] IDX_C00 = 2'd0;
  localparam logic [1:0] IDX_C01 = 2'd1;
  localparam logic [1:0] IDX_C10 = 2'd2;
  localparam logic [1:0] IDX_C11 = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/systolic_result_collector_2x2.sv
// Waits a fixed settle time after start, snapshots the four PE accumulators
// and drains them row-major over a valid/ready stream, then pulses done.
module systolic_result_collector_2x2
  import systolic_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEFAULT,
  parameter int SETTLE_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] c00,
  input  logic [DATA_W-1:0] c01,
  input  logic [DATA_W-1:0] c10,
  input  logic [DATA_W-1:0] c11,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_idx,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic [7:0]        cnt;
  logic [1:0]        idx;
  logic [DATA_W-1:0] shadow [NUM_ELEMS];
  logic              settled;
  logic              fire;

  assign settled = (state == WAIT) && (cnt == SETTLE_LAST);
  assign fire    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= IDX_C00;
      for (int i = 0; i < NUM_ELEMS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= '0;
          end
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          // Snapshot is taken once; later accumulator activity cannot disturb the drain.
          if (settled) begin
            shadow[IDX_C00] <= c00;
            shadow[IDX_C01] <= c01;
            shadow[IDX_C10] <= c10;
            shadow[IDX_C11] <= c11;
            idx             <= IDX_C00;
          end
        end
        DRAIN: begin
          if (fire) begin
            idx <= idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = WAIT;
      WAIT:    if (settled) state_next = DRAIN;
      DRAIN:   if (fire && idx == IDX_C11) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs depend only on registered state, so out_ready never reaches out_valid.
  always_comb begin
    out_valid = (state == DRAIN);
    out_idx   = idx;
    out_last  = out_valid && (idx == IDX_C11);
    out_data  = out_valid ? shadow[idx] : '0;
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

endmodule
